// File: rtl/reg_file_scoreboard_if.sv
// rtl/reg_file_scoreboard_if.sv - decode read/issue and write-back bus for the register file scoreboard
interface reg_file_scoreboard_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              rd_req;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic              issue_en;
  logic [ADDR_W-1:0] rd_issue;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] ans_wb;
  logic              stall;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              rd_valid;
  logic              wb_orphan;

  modport master (
    output rd_req, rs_addr, rt_addr, issue_en, rd_issue, wb_en, wb_addr, ans_wb,
    input  stall, rs_data, rt_data, rd_valid, wb_orphan
  );

  modport slave (
    input  rd_req, rs_addr, rt_addr, issue_en, rd_issue, wb_en, wb_addr, ans_wb,
    output stall, rs_data, rt_data, rd_valid, wb_orphan
  );
endinterface

// File: rtl/reg_file_scoreboard.sv
// rtl/reg_file_scoreboard.sv - register file with write-back bypass and per-register pending-write scoreboard
module reg_file_scoreboard #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  reg_file_scoreboard_if.slave  bus
);
  localparam int NREG = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] regs [NREG];
  logic [CNT_W-1:0]  cnt  [NREG];

  logic [NREG-1:0]   wb_hit;
  logic [NREG-1:0]   pend;
  logic              haz_rs, haz_rt, full, accept;
  logic [DATA_W-1:0] rs_byp, rt_byp;

  // A write-back arriving this cycle retires one outstanding write early
  always_comb begin
    wb_hit = '0;
    pend   = '0;
    for (int i = 0; i < NREG; i++) begin
      wb_hit[i] = bus.wb_en && (bus.wb_addr == ADDR_W'(i));
      pend[i]   = (cnt[i] > CNT_W'(1)) || ((cnt[i] == CNT_W'(1)) && !wb_hit[i]);
    end
  end

  always_comb begin
    haz_rs = bus.rd_req && (bus.rs_addr != '0) && pend[bus.rs_addr];
    haz_rt = bus.rd_req && (bus.rt_addr != '0) && pend[bus.rt_addr];
    full   = bus.issue_en && (bus.rd_issue != '0) &&
             (cnt[bus.rd_issue] == CNT_MAX) && !wb_hit[bus.rd_issue];
    accept = !(haz_rs || haz_rt || full);
  end

  assign bus.stall = !accept;

  always_comb begin
    rs_byp = '0;
    rt_byp = '0;
    if (bus.rs_addr != '0)
      rs_byp = wb_hit[bus.rs_addr] ? bus.ans_wb : regs[bus.rs_addr];
    if (bus.rt_addr != '0)
      rt_byp = wb_hit[bus.rt_addr] ? bus.ans_wb : regs[bus.rt_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end
      bus.rs_data   <= '0;
      bus.rt_data   <= '0;
      bus.rd_valid  <= 1'b0;
      bus.wb_orphan <= 1'b0;
    end else begin
      if (bus.wb_en && (bus.wb_addr != '0))
        regs[bus.wb_addr] <= bus.ans_wb;

      if (bus.rd_req && accept) begin
        bus.rs_data  <= rs_byp;
        bus.rt_data  <= rt_byp;
        bus.rd_valid <= 1'b1;
      end else begin
        bus.rd_valid <= 1'b0;
      end

      bus.wb_orphan <= bus.wb_en && (bus.wb_addr != '0) && (cnt[bus.wb_addr] == '0);

      // Simultaneous issue and retire to one register leaves its count unchanged
      for (int i = 1; i < NREG; i++) begin
        if ((bus.issue_en && accept && (bus.rd_issue == ADDR_W'(i))) &&
            !(wb_hit[i] && (cnt[i] != '0)))
          cnt[i] <= cnt[i] + CNT_W'(1);
        else if (!(bus.issue_en && accept && (bus.rd_issue == ADDR_W'(i))) &&
                 (wb_hit[i] && (cnt[i] != '0)))
          cnt[i] <= cnt[i] - CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_reg_file_scoreboard.sv
// tb/tb_reg_file_scoreboard.sv - directed-vector bench for reg_file_scoreboard
module tb_reg_file_scoreboard;
  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  reg_file_scoreboard_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  reg_file_scoreboard #(.DATA_W(16), .ADDR_W(3), .CNT_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.rd_req   = 1'b0;
    bus.rs_addr  = '0;
    bus.rt_addr  = '0;
    bus.issue_en = 1'b0;
    bus.rd_issue = '0;
    bus.wb_en    = 1'b0;
    bus.wb_addr  = '0;
    bus.ans_wb   = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    step();
    step();
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall got %b want 0", bus.stall); end
    vectors++;
    if (bus.rs_data !== 16'h0 || bus.rt_data !== 16'h0) begin
      miscompares++; $display("FAIL reset_data got %h/%h want 0000/0000", bus.rs_data, bus.rt_data);
    end
    vectors++;
    if (bus.rd_valid !== 1'b0 || bus.wb_orphan !== 1'b0) begin
      miscompares++; $display("FAIL reset_flags got rd_valid=%b orphan=%b want 0/0", bus.rd_valid, bus.wb_orphan);
    end
  endtask

  task automatic test_write_read();
    bus.wb_en = 1'b1; bus.wb_addr = 3'd3; bus.ans_wb = 16'hABCD;
    step();
    idle();
    vectors++;
    if (bus.wb_orphan !== 1'b1) begin miscompares++; $display("FAIL wr_orphan got %b want 1", bus.wb_orphan); end
    bus.rd_req = 1'b1; bus.rs_addr = 3'd3; bus.rt_addr = 3'd0;
    #1;
    vectors++;
    if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL wr_stall got %b want 0", bus.stall); end
    step();
    idle();
    vectors++;
    if (bus.rs_data !== 16'hABCD || bus.rt_data !== 16'h0 || bus.rd_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_read got rs=%h rt=%h v=%b want abcd/0000/1", bus.rs_data, bus.rt_data, bus.rd_valid);
    end
  endtask

  task automatic test_bypass();
    bus.wb_en = 1'b1; bus.wb_addr = 3'd5; bus.ans_wb = 16'hFFFF;
    bus.rd_req = 1'b1; bus.rs_addr = 3'd5; bus.rt_addr = 3'd3;
    #1;
    vectors++;
    if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL byp_stall got %b want 0", bus.stall); end
    step();
    idle();
    vectors++;
    if (bus.rs_data !== 16'hFFFF || bus.rt_data !== 16'hABCD || bus.rd_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL byp_read got rs=%h rt=%h v=%b want ffff/abcd/1", bus.rs_data, bus.rt_data, bus.rd_valid);
    end
  endtask

  task automatic test_scoreboard();
    bus.issue_en = 1'b1; bus.rd_issue = 3'd2;
    #1;
    vectors++;
    if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL sb_issue got %b want 0", bus.stall); end
    step();
    idle();
    bus.rd_req = 1'b1; bus.rs_addr = 3'd0; bus.rt_addr = 3'd2;
    #1;
    vectors++;
    if (bus.stall !== 1'b1) begin miscompares++; $display("FAIL sb_rt_haz got %b want 1", bus.stall); end
    bus.rs_addr = 3'd2; bus.rt_addr = 3'd0;
    #1;
    vectors++;
    if (bus.stall !== 1'b1) begin miscompares++; $display("FAIL sb_rs_haz got %b want 1", bus.stall); end
    step();
    vectors++;
    if (bus.rd_valid !== 1'b0 || bus.rs_data !== 16'hFFFF) begin
      miscompares++; $display("FAIL sb_stalled got v=%b rs=%h want 0/ffff", bus.rd_valid, bus.rs_data);
    end
    bus.wb_en = 1'b1; bus.wb_addr = 3'd2; bus.ans_wb = 16'hDCBA;
    #1;
    vectors++;
    if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL sb_retry got %b want 0", bus.stall); end
    step();
    idle();
    vectors++;
    if (bus.rs_data !== 16'hDCBA || bus.rd_valid !== 1'b1 || bus.wb_orphan !== 1'b0) begin
      miscompares++;
      $display("FAIL sb_read got rs=%h v=%b orphan=%b want dcba/1/0", bus.rs_data, bus.rd_valid, bus.wb_orphan);
    end
  endtask

  task automatic test_saturation();
    logic [15:0] drain [3];
    drain[0] = 16'h00A1; drain[1] = 16'h00A2; drain[2] = 16'h00A3;
    for (int i = 0; i < 3; i++) begin
      bus.issue_en = 1'b1; bus.rd_issue = 3'd4;
      #1;
      vectors++;
      if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL sat_issue%0d got %b want 0", i, bus.stall); end
      step();
    end
    bus.issue_en = 1'b1; bus.rd_issue = 3'd4;
    #1;
    vectors++;
    if (bus.stall !== 1'b1) begin miscompares++; $display("FAIL sat_full got %b want 1", bus.stall); end
    step();
    bus.wb_en = 1'b1; bus.wb_addr = 3'd4; bus.ans_wb = 16'h4444;
    #1;
    vectors++;
    if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL sat_issue_wb got %b want 0", bus.stall); end
    step();
    idle();
    vectors++;
    if (bus.wb_orphan !== 1'b0) begin miscompares++; $display("FAIL sat_wb_orphan got %b want 0", bus.wb_orphan); end
    bus.issue_en = 1'b1; bus.rd_issue = 3'd4;
    #1;
    vectors++;
    if (bus.stall !== 1'b1) begin miscompares++; $display("FAIL sat_still_full got %b want 1", bus.stall); end
    idle();
    for (int i = 0; i < 3; i++) begin
      bus.wb_en = 1'b1; bus.wb_addr = 3'd4; bus.ans_wb = drain[i];
      bus.rd_req = 1'b1; bus.rs_addr = 3'd4;
      #1;
      vectors++;
      if (bus.stall !== (i < 2 ? 1'b1 : 1'b0)) begin
        miscompares++; $display("FAIL sat_drain_stall%0d got %b want %b", i, bus.stall, (i < 2 ? 1'b1 : 1'b0));
      end
      bus.rd_req = 1'b0;
      step();
      vectors++;
      if (bus.wb_orphan !== 1'b0) begin miscompares++; $display("FAIL sat_drain_orphan%0d got %b want 0", i, bus.wb_orphan); end
    end
    idle();
    bus.rd_req = 1'b1; bus.rs_addr = 3'd4;
    step();
    idle();
    vectors++;
    if (bus.rs_data !== 16'h00A3 || bus.rd_valid !== 1'b1) begin
      miscompares++; $display("FAIL sat_final_read got rs=%h v=%b want 00a3/1", bus.rs_data, bus.rd_valid);
    end
    bus.wb_en = 1'b1; bus.wb_addr = 3'd4; bus.ans_wb = 16'h00A4;
    step();
    idle();
    vectors++;
    if (bus.wb_orphan !== 1'b1) begin miscompares++; $display("FAIL sat_extra_wb got %b want 1", bus.wb_orphan); end
  endtask

  task automatic test_orphan_r0();
    bus.wb_en = 1'b1; bus.wb_addr = 3'd6; bus.ans_wb = 16'h1234;
    step();
    idle();
    vectors++;
    if (bus.wb_orphan !== 1'b1) begin miscompares++; $display("FAIL orph_pulse got %b want 1", bus.wb_orphan); end
    bus.rd_req = 1'b1; bus.rs_addr = 3'd6;
    step();
    idle();
    vectors++;
    if (bus.wb_orphan !== 1'b0 || bus.rs_data !== 16'h1234) begin
      miscompares++; $display("FAIL orph_commit got orphan=%b rs=%h want 0/1234", bus.wb_orphan, bus.rs_data);
    end
    bus.wb_en = 1'b1; bus.wb_addr = 3'd0; bus.ans_wb = 16'hFFFF;
    bus.rd_req = 1'b1; bus.rs_addr = 3'd0; bus.rt_addr = 3'd6;
    step();
    idle();
    vectors++;
    if (bus.rs_data !== 16'h0 || bus.rt_data !== 16'h1234 || bus.wb_orphan !== 1'b0) begin
      miscompares++;
      $display("FAIL r0_bypass got rs=%h rt=%h orphan=%b want 0000/1234/0", bus.rs_data, bus.rt_data, bus.wb_orphan);
    end
    bus.rd_req = 1'b1; bus.rs_addr = 3'd6; bus.rt_addr = 3'd0;
    step();
    idle();
    vectors++;
    if (bus.rs_data !== 16'h1234 || bus.rt_data !== 16'h0) begin
      miscompares++; $display("FAIL r0_read got rs=%h rt=%h want 1234/0000", bus.rs_data, bus.rt_data);
    end
  endtask

  task automatic test_back_to_back();
    bus.wb_en = 1'b1; bus.wb_addr = 3'd3; bus.ans_wb = 16'h0033;
    step();
    idle();
    bus.issue_en = 1'b1; bus.rd_issue = 3'd3;
    bus.rd_req = 1'b1; bus.rs_addr = 3'd3; bus.rt_addr = 3'd3;
    #1;
    vectors++;
    if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL b2b_self_stall got %b want 0", bus.stall); end
    step();
    idle();
    vectors++;
    if (bus.rs_data !== 16'h0033 || bus.rt_data !== 16'h0033) begin
      miscompares++; $display("FAIL b2b_old_value got rs=%h rt=%h want 0033/0033", bus.rs_data, bus.rt_data);
    end
    bus.rd_req = 1'b1; bus.rs_addr = 3'd3;
    #1;
    vectors++;
    if (bus.stall !== 1'b1) begin miscompares++; $display("FAIL b2b_pending got %b want 1", bus.stall); end
    bus.wb_en = 1'b1; bus.wb_addr = 3'd3; bus.ans_wb = 16'h0077;
    #1;
    vectors++;
    if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL b2b_release got %b want 0", bus.stall); end
    step();
    idle();
    vectors++;
    if (bus.rs_data !== 16'h0077 || bus.rd_valid !== 1'b1) begin
      miscompares++; $display("FAIL b2b_read got rs=%h v=%b want 0077/1", bus.rs_data, bus.rd_valid);
    end
  endtask

  task automatic test_reset_mid();
    bus.issue_en = 1'b1; bus.rd_issue = 3'd1;
    step();
    idle();
    reset = 1'b1;
    bus.wb_en = 1'b1; bus.wb_addr = 3'd1; bus.ans_wb = 16'h5555;
    bus.rd_req = 1'b1; bus.rs_addr = 3'd6;
    step();
    reset = 1'b0;
    idle();
    vectors++;
    if (bus.rd_valid !== 1'b0 || bus.rs_data !== 16'h0 || bus.wb_orphan !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_out got v=%b rs=%h orphan=%b want 0/0000/0", bus.rd_valid, bus.rs_data, bus.wb_orphan);
    end
    bus.rd_req = 1'b1; bus.rs_addr = 3'd1; bus.rt_addr = 3'd6;
    #1;
    vectors++;
    if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL rst_mid_stall got %b want 0", bus.stall); end
    step();
    idle();
    vectors++;
    if (bus.rs_data !== 16'h0 || bus.rt_data !== 16'h0 || bus.rd_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_read got rs=%h rt=%h v=%b want 0000/0000/1", bus.rs_data, bus.rt_data, bus.rd_valid);
    end
    bus.wb_en = 1'b1; bus.wb_addr = 3'd1; bus.ans_wb = 16'h5555;
    step();
    idle();
    vectors++;
    if (bus.wb_orphan !== 1'b1) begin miscompares++; $display("FAIL rst_mid_late_wb got %b want 1", bus.wb_orphan); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    idle();
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_saturation();
    test_orphan_r0();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/reg_file_scoreboard.md
# reg_file_scoreboard

Destination end of the write-back path in the 16-bit MIPS pipeline: accepts `ans_wb` results from `write_back_block` and commits them into the architectural register file. It serves the decode stage's two source operands through a registered read port with same-cycle write-back bypass. A per-register pending-write scoreboard raises `stall` until every outstanding write-back for a source operand has arrived.

## Interface
Parameters:
- DATA_W, 16, register/data width
- ADDR_W, 3, register address width (2**ADDR_W registers, R0 hard-wired zero)
- CNT_W, 2, per-register pending-write counter width (max outstanding = 2**CNT_W-1)

Ports (one clock, `clk`; reset `reset` is synchronous and active-high):
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- rd_req  in  1  decode requests operand read this cycle
- rs_addr  in  ADDR_W  source register 1
- rt_addr  in  ADDR_W  source register 2
- issue_en  in  1  decode issues an instruction that will write rd_issue
- rd_issue  in  ADDR_W  destination of issued instruction
- wb_en  in  1  write-back valid
- wb_addr  in  ADDR_W  write-back destination
- ans_wb  in  DATA_W  write-back data
- stall  out  1  combinational; request/issue rejected this cycle
- rs_data  out  DATA_W  registered operand 1
- rt_data  out  DATA_W  registered operand 2
- rd_valid  out  1  registered; operands updated on previous edge
- wb_orphan  out  1  registered one-cycle pulse; write-back to register with no pending write

## Operation
- Register file: regs[1..2**ADDR_W-1]; R0 reads 0, writes to R0 ignored (data and scoreboard).
- Commit: on edge, if wb_en && wb_addr!=0 and not reset: regs[wb_addr] <= ans_wb.
- Bypass: operand for address a = 0 if a==0; else ans_wb if wb_en && wb_addr==a; else regs[a].
- Scoreboard cnt[r] (CNT_W bits). Effective pending of r: cnt[r]>1, or cnt[r]==1 and not (wb_en && wb_addr==r).
- Hazards: haz_rs = rd_req && rs_addr!=0 && pending(rs_addr); haz_rt likewise; full = issue_en && rd_issue!=0 && cnt[rd_issue]==max && not (wb_en && wb_addr==rd_issue).
- stall = haz_rs | haz_rt | full. Read and issue belong to one instruction: stall blocks both.
- accept = !stall. Read: if rd_req && accept: rs_data/rt_data <= bypassed values, rd_valid <= 1; else rd_valid <= 0, data outputs hold.
- Counter update per r: +1 if issue_en && accept && rd_issue==r && r!=0; -1 if wb_en && wb_addr==r && r!=0 && cnt[r]>0; both -> unchanged.
- Orphan: wb_en && wb_addr!=0 && cnt[wb_addr]==0 -> data still committed, counter stays 0, wb_orphan <= 1 next cycle; otherwise wb_orphan <= 0.
- Read of rd_issue by the same instruction (e.g. add r3,r3,r1) uses the old value; pending set only after the edge.

## Timing
- Reset (edge with reset=1): all regs 0, all cnt 0, rs_data=rt_data=0, rd_valid=0, wb_orphan=0. Write-back, issue, read in the reset cycle are discarded; in-flight writes become orphans afterwards.
- Write latency: ans_wb visible in regs at the next edge; visible to a same-cycle read via bypass (zero added latency).
- Read latency: 1 cycle, rd_req at edge N -> rs_data/rt_data/rd_valid valid after edge N+1.
- stall is purely combinational from current inputs and state; no registered stall.
- Simultaneous issue and write-back to same register at max count: allowed (no stall), count unchanged.
- Counter never wraps: increment at max is prevented by `full`; decrement at 0 prevented (orphan).

## Test plan
- Reset then write-back R3=16'hABCD; next cycle rd_req rs=3, rt=0 -> after edge rs_data=16'hABCD, rt_data=0, rd_valid=1.
- Same-cycle bypass: wb R5=16'hFFFF and rd_req rs=5 together, no pending -> stall=0, rs_data=16'hFFFF next cycle.
- Scoreboard: issue rd=2; next cycle rd_req rs=2 -> stall=1, rd_valid=0; wb R2=16'hDCBA same cycle as retry -> stall=0, rs_data=16'hDCBA.
- Counter saturation: three issues to R4 accepted, fourth issue_en rd=4 -> stall=1; fourth with wb R4 same cycle -> accepted, cnt stays 3.
- Orphan and R0: wb R6=16'h1234 with cnt 0 -> wb_orphan=1 for one cycle, regs[6]=16'h1234; wb R0=16'hFFFF -> read R0 returns 0, no orphan.
- Reset mid-operation: issue R1, assert reset with wb R1=16'h5555 -> after reset R1 reads 0, no stall on R1, rd_valid=0.
